pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
//  Combines three hazard sources into per-register hold/bubble controls:
//    - load-use data hazards (ID/EX load feeding the IF/ID consumer);
//    - taken-branch flushes (resolved in EX);
//    - multi-cycle data-memory waits (req/ack handshake in MEM).
//  Also keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
//  XLEN         32  instruction/register width; opcode constants come from define.v
//  LU_STALL     1   load-use stall cycles (1 = MEM->EX forwarding present, 2 = none)
//  CNT_W        16  width of the performance counters
// PORTS
//  i_clk            in   1      rising-edge clock
//  i_rst            in   1      reset, synchronous, active-high
//  i_if_id_instr    in   XLEN   instruction in IF/ID (consumer candidate)
//  i_id_ex_instr    in   XLEN   instruction in ID/EX (producer candidate)
//  i_taken_branch   in   1      EX-stage branch/jump resolved taken this cycle
//  i_dmem_req       in   1      MEM stage issuing a data access this cycle
//  i_dmem_ack       in   1      data memory completes the access this cycle
//  o_hold_pc        out  1      PC keeps its value
//  o_hold_if_id     out  1      IF/ID keeps its value
//  o_hold_id_ex     out  1      ID/EX keeps its value
//  o_hold_ex_mem    out  1      EX/MEM keeps its value
//  o_bubble_id_ex   out  1      ID/EX loads a NOP (0x00000013)
//  o_bubble_mem_wb  out  1      MEM/WB loads a NOP
//  o_flush_if_id    out  1      IF/ID loads a NOP
//  o_state          out  2      FSM state: 0=RUN, 1=LU_STALL, 2=MEM_WAIT
//  o_stall_cnt      out  CNT_W  cycles with o_hold_pc=1, saturating at all-ones
//  o_flush_cnt      out  CNT_W  taken-branch flush events, saturating at all-ones
// BEHAVIOUR
//  Reset
//    - While i_rst=1, all control outputs are 0 (combinational gate).
//    - On the clock edge: state<=RUN, lu_cnt<=0, both counters <=0.
//    - Reset mid-stall abandons the stall immediately.
//  Load-use detect (lu_hit), combinational:
//    - Condition: id_ex opcode==`LOAD, rd!=x0, and either:
//        - rs1==rd and the consumer reads rs1 (OP, OP_IMM, LOAD, STORE, BRANCH, JALR), or
//        - rs2==rd and the consumer reads rs2 (OP, STORE, BRANCH).
//    - LUI, AUIPC and JAL never hit.
//  Mem-wait detect: mw_hit = i_dmem_req & ~i_dmem_ack.
//  Priority: mw_hit > i_taken_branch > lu_hit. Outputs are Mealy: they act in the detect cycle.
//  RUN
//    - mw_hit: hold pc, if_id, id_ex, ex_mem; bubble mem_wb; next state MEM_WAIT.
//    - else taken_branch: flush_if_id=1, bubble_id_ex=1, no holds; lu_hit ignored (consumer squashed).
//    - else lu_hit: hold pc and if_id, bubble_id_ex. If LU_STALL>1, go to LU_STALL with lu_cnt=LU_STALL-1.
//    - else all outputs 0.
//  LU_STALL
//    - Same outputs as an RUN lu_hit cycle.
//    - lu_cnt decrements; go to RUN when lu_cnt reaches 1.
//    - mw_hit pre-empts: enter MEM_WAIT and preserve lu_cnt.
//  MEM_WAIT
//    - Holds and mem_wb bubble persist while ~i_dmem_ack.
//    - Ack cycle: holds drop. Apply branch flush or load-use from the current inputs as in RUN.
//    - If lu_cnt!=0, return to LU_STALL; otherwise go to RUN.
//    - i_taken_branch stays stable while waiting because EX is frozen.
//  Handshake
//    - req and ack in the same cycle: zero stall.
//    - ack without req is ignored in RUN.
//  Counters: +1 per qualifying cycle, saturating; never wrap.
// STRUCTURE
//  - define.v (shared): `XLEN, opcodes `LOAD, `STORE, `OP, `OP_IMM, `BRANCH, `JALR, `JAL,
//    `LUI, `AUIPC, state encodings `HZ_RUN, `HZ_LU, `HZ_MW, `NOP_INSTR.
//  - Sub-module load_use_detect: purely combinational lu_hit from the two instruction words.
//  - Top level: FSM, lu_cnt, output decode, counters.
// TESTING
//  1. id_ex=0x0000A283 (lw x5,0(x1)), if_id=0x00728333 (add x6,x5,x7), LU_STALL=1
//     -> hold_pc=hold_if_id=bubble_id_ex=1 for exactly 1 cycle; stall_cnt=1.
//  2. Same pair with LU_STALL=2 -> 2 consecutive stall cycles, o_state=1 on the 2nd; stall_cnt=2.
//  3. id_ex=0x0000A003 (lw x0) with the same consumer -> no stall;
//     consumer 0x005002B7 (lui x5) after lw x5 -> no stall.
//  4. lu_hit and i_taken_branch in the same cycle -> flush_if_id=bubble_id_ex=1, no holds;
//     flush_cnt=1, stall_cnt=0.
//  5. dmem_req=1, ack low 3 cycles then high -> holds+bubble_mem_wb for 3 cycles, released on ack;
//     stall_cnt=3; req with ack the same cycle -> 0 stalls.
//  6. i_rst=1 asserted during MEM_WAIT -> outputs 0 that cycle, o_state=0 and counters 0 next cycle.
//     Counter forced to 0xFFFE plus 3 stalls -> reads 0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcodes, FSM encoding and control-vector constants for the hazard sequencer.
// Pure definitions: no logic, no latency.
package pipeline_hazard_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        HZ_RUN = 2'd0,
        HZ_LU  = 2'd1,
        HZ_MW  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic hold_pc;
        logic hold_if_id;
        logic hold_id_ex;
        logic hold_ex_mem;
        logic bubble_id_ex;
        logic bubble_mem_wb;
        logic flush_if_id;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_IDLE  = 7'b000_0000;
    localparam hz_ctl_t CTL_MW    = 7'b111_1010;
    localparam hz_ctl_t CTL_FLUSH = 7'b000_0101;
    localparam hz_ctl_t CTL_LU    = 7'b110_0100;

    function automatic logic reads_rs1(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: ID/EX load whose rd feeds a source read by the IF/ID instruction.
// Zero latency; no handshake.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] if_id_instr,
    input  logic [XLEN-1:0] id_ex_instr,
    output logic            lu_hit
);

    logic [6:0] prod_opc;
    logic [6:0] cons_opc;
    logic [4:0] prod_rd;
    logic [4:0] cons_rs1;
    logic [4:0] cons_rs2;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign prod_opc = id_ex_instr[6:0];
    assign prod_rd  = id_ex_instr[11:7];
    assign cons_opc = if_id_instr[6:0];
    assign cons_rs1 = if_id_instr[19:15];
    assign cons_rs2 = if_id_instr[24:20];

    // LUI/AUIPC/JAL fall out of both read sets, so they never match.
    assign rs1_hit = reads_rs1(cons_opc) && (cons_rs1 == prod_rd);
    assign rs2_hit = reads_rs2(cons_opc) && (cons_rs2 == prod_rd);

    assign lu_hit = (prod_opc == OPC_LOAD) && (prod_rd != 5'd0) && (rs1_hit || rs2_hit);

    assign unused_bits = ^{if_id_instr[XLEN-1:25], if_id_instr[14:7], id_ex_instr[XLEN-1:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy hold/bubble/flush controls plus perf counters.
// Controls act in the detect cycle; memory waits freeze PC..EX/MEM until ack.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_if_id_instr,
    input  logic [XLEN-1:0]  i_id_ex_instr,
    input  logic             i_taken_branch,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_hold_pc,
    output logic             o_hold_if_id,
    output logic             o_hold_id_ex,
    output logic             o_hold_ex_mem,
    output logic             o_bubble_id_ex,
    output logic             o_bubble_mem_wb,
    output logic             o_flush_if_id,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int LU_W = (LU_STALL > 1) ? $clog2(LU_STALL + 1) : 1;
    localparam logic [LU_W-1:0] LU_INIT = LU_W'(LU_STALL - 1);

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [LU_W-1:0]  lu_cnt_q;
    logic [LU_W-1:0]  lu_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             lu_hit;
    logic             mw_hit;
    logic             lu_enter;
    hz_ctl_t          ctl;

    load_use_detect #(
        .XLEN(XLEN)
    ) u_load_use_detect (
        .if_id_instr(i_if_id_instr),
        .id_ex_instr(i_id_ex_instr),
        .lu_hit     (lu_hit)
    );

    assign mw_hit   = i_dmem_req & ~i_dmem_ack;
    // A flushed consumer never needs the multi-cycle stall.
    assign lu_enter = ~i_taken_branch & lu_hit & (LU_STALL > 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= HZ_RUN;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (mw_hit) begin
                    state_d = HZ_MW;
                end else if (lu_enter) begin
                    state_d  = HZ_LU;
                    lu_cnt_d = LU_INIT;
                end
            end
            HZ_LU: begin
                if (mw_hit) begin
                    state_d = HZ_MW;
                end else begin
                    lu_cnt_d = lu_cnt_q - LU_W'(1);
                    if (lu_cnt_q <= LU_W'(1)) begin
                        state_d = HZ_RUN;
                    end
                end
            end
            HZ_MW: begin
                // lu_cnt survives the wait so an interrupted load-use stall resumes.
                if (i_dmem_ack) begin
                    if (lu_cnt_q != '0) begin
                        state_d = HZ_LU;
                    end else if (lu_enter) begin
                        state_d  = HZ_LU;
                        lu_cnt_d = LU_INIT;
                    end else begin
                        state_d = HZ_RUN;
                    end
                end
            end
            default: begin
                state_d  = HZ_RUN;
                lu_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ctl = CTL_IDLE;
        case (state_q)
            HZ_RUN: begin
                if (mw_hit)              ctl = CTL_MW;
                else if (i_taken_branch) ctl = CTL_FLUSH;
                else if (lu_hit)         ctl = CTL_LU;
            end
            HZ_LU: begin
                ctl = mw_hit ? CTL_MW : CTL_LU;
            end
            HZ_MW: begin
                if (!i_dmem_ack)         ctl = CTL_MW;
                else if (i_taken_branch) ctl = CTL_FLUSH;
                else if (lu_hit)         ctl = CTL_LU;
            end
            default: ctl = CTL_IDLE;
        endcase
        if (i_rst) begin
            ctl = CTL_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctl.hold_pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ctl.flush_if_id && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_hold_pc       = ctl.hold_pc;
    assign o_hold_if_id    = ctl.hold_if_id;
    assign o_hold_id_ex    = ctl.hold_id_ex;
    assign o_hold_ex_mem   = ctl.hold_ex_mem;
    assign o_bubble_id_ex  = ctl.bubble_id_ex;
    assign o_bubble_mem_wb = ctl.bubble_mem_wb;
    assign o_flush_if_id   = ctl.flush_if_id;
    assign o_state         = state_q;
    assign o_stall_cnt     = stall_cnt_q;
    assign o_flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LU_STALL=1/CNT_W=16 and LU_STALL=2/CNT_W=2)
// share stimulus; a reference model fills a scoreboard that a negedge monitor drains.
module tb_pipeline_hazard_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] if_id = 32'h13;
    logic [31:0] id_ex = 32'h13;
    logic        br    = 1'b0;
    logic        req   = 1'b0;
    logic        ack   = 1'b0;

    logic        h_pc1, h_ifid1, h_idex1, h_exmem1, b_idex1, b_memwb1, f_ifid1;
    logic [1:0]  st1;
    logic [15:0] sc1, fc1;
    logic        h_pc2, h_ifid2, h_idex2, h_exmem2, b_idex2, b_memwb2, f_ifid2;
    logic [1:0]  st2;
    logic [1:0]  sc2, fc2;

    always #5 i_clk = ~i_clk;

    pipeline_hazard_ctrl #(.XLEN(32), .LU_STALL(1), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_id_instr(if_id), .i_id_ex_instr(id_ex),
        .i_taken_branch(br), .i_dmem_req(req), .i_dmem_ack(ack),
        .o_hold_pc(h_pc1), .o_hold_if_id(h_ifid1), .o_hold_id_ex(h_idex1), .o_hold_ex_mem(h_exmem1),
        .o_bubble_id_ex(b_idex1), .o_bubble_mem_wb(b_memwb1), .o_flush_if_id(f_ifid1),
        .o_state(st1), .o_stall_cnt(sc1), .o_flush_cnt(fc1));

    pipeline_hazard_ctrl #(.XLEN(32), .LU_STALL(2), .CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_id_instr(if_id), .i_id_ex_instr(id_ex),
        .i_taken_branch(br), .i_dmem_req(req), .i_dmem_ack(ack),
        .o_hold_pc(h_pc2), .o_hold_if_id(h_ifid2), .o_hold_id_ex(h_idex2), .o_hold_ex_mem(h_exmem2),
        .o_bubble_id_ex(b_idex2), .o_bubble_mem_wb(b_memwb2), .o_flush_if_id(f_ifid2),
        .o_state(st2), .o_stall_cnt(sc2), .o_flush_cnt(fc2));

    typedef struct {
        logic [6:0] ctl1;
        int         st1;
        int         sc1;
        int         fc1;
        logic [6:0] ctl2;
        int         st2;
        int         sc2;
        int         fc2;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: per instance, "in a memory wait" flag, load-use cycles still owed, event counts.
    bit   m_mw[2];
    int   m_left[2];
    int   m_sc[2];
    int   m_fc[2];
    int   m_lst[2] = '{1, 2};
    int   m_max[2] = '{65535, 3};

    // {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, bubble_id_ex, bubble_mem_wb, flush_if_id}
    localparam logic [6:0] E_MW = 7'b1111010;
    localparam logic [6:0] E_FL = 7'b0000101;
    localparam logic [6:0] E_LU = 7'b1100100;

    function automatic bit model_lu_hit(input logic [31:0] cons, input logic [31:0] prod);
        int unsigned c  = cons;
        int unsigned p  = prod;
        int unsigned po = p % 128;
        int unsigned rd = (p / 128) % 32;
        int unsigned co = c % 128;
        int unsigned r1 = (c / 32768) % 32;
        int unsigned r2 = (c / 1048576) % 32;
        bit uses1 = (co == 3) || (co == 19) || (co == 35) || (co == 51) || (co == 99) || (co == 103);
        bit uses2 = (co == 35) || (co == 51) || (co == 99);
        return (po == 3) && (rd != 0) && ((uses1 && r1 == rd) || (uses2 && r2 == rd));
    endfunction

    task automatic model_cycle(input int d, input bit lu,
                               output logic [6:0] ctl, output int st, output int sc, output int fc);
        bit mwh = req && !ack;
        st  = m_mw[d] ? 2 : (m_left[d] > 0 ? 1 : 0);
        sc  = m_sc[d];
        fc  = m_fc[d];
        ctl = 7'b0;
        if (i_rst) begin
            m_mw[d] = 0; m_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
        end else begin
            if (m_mw[d]) begin
                if (!ack) begin
                    ctl = E_MW;
                end else begin
                    m_mw[d] = 0;
                    if (br)      ctl = E_FL;
                    else if (lu) ctl = E_LU;
                    if (m_left[d] == 0 && !br && lu && m_lst[d] > 1) m_left[d] = m_lst[d] - 1;
                end
            end else if (m_left[d] > 0) begin
                if (mwh) begin
                    ctl = E_MW; m_mw[d] = 1;
                end else begin
                    ctl = E_LU; m_left[d]--;
                end
            end else begin
                if (mwh) begin
                    ctl = E_MW; m_mw[d] = 1;
                end else if (br) begin
                    ctl = E_FL;
                end else if (lu) begin
                    ctl = E_LU;
                    if (m_lst[d] > 1) m_left[d] = m_lst[d] - 1;
                end
            end
            if (ctl[6] && m_sc[d] < m_max[d]) m_sc[d]++;
            if (ctl[0] && m_fc[d] < m_max[d]) m_fc[d]++;
        end
    endtask

    // Applies one cycle of inputs at posedge+1, queues the expected response, advances to the next cycle.
    task automatic step(input bit rst, input logic [31:0] ci, input logic [31:0] pi,
                        input bit b, input bit rq, input bit ak);
        exp_t e;
        bit   lu;
        i_rst = rst; if_id = ci; id_ex = pi; br = b; req = rq; ack = ak;
        lu = model_lu_hit(ci, pi);
        model_cycle(0, lu, e.ctl1, e.st1, e.sc1, e.fc1);
        model_cycle(1, lu, e.ctl2, e.st2, e.sc2, e.fc2);
        sb.push_back(e);
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctl_lu1",   {h_pc1, h_ifid1, h_idex1, h_exmem1, b_idex1, b_memwb1, f_ifid1}, 32'(e.ctl1));
                chk("state_lu1", 32'(st1), e.st1);
                chk("stall_lu1", 32'(sc1), e.sc1);
                chk("flush_lu1", 32'(fc1), e.fc1);
                chk("ctl_lu2",   {h_pc2, h_ifid2, h_idex2, h_exmem2, b_idex2, b_memwb2, f_ifid2}, 32'(e.ctl2));
                chk("state_lu2", 32'(st2), e.st2);
                chk("stall_lu2", 32'(sc2), e.sc2);
                chk("flush_lu2", 32'(fc2), e.fc2);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h67, 7'h6f, 7'h37, 7'h17};
        logic [4:0] rd  = 5'($urandom_range(0, 3));
        logic [4:0] rs1 = 5'($urandom_range(0, 3));
        logic [4:0] rs2 = 5'($urandom_range(0, 3));
        return {7'b0, rs2, rs1, 3'b010, rd, opcs[$urandom_range(0, 8)]};
    endfunction

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LW5  = 32'h0000_A283;
    localparam logic [31:0] ADD  = 32'h0072_8333;
    localparam logic [31:0] LW0  = 32'h0000_A003;
    localparam logic [31:0] LUI5 = 32'h0050_02B7;

    initial begin : driver
        repeat (2) @(posedge i_clk);
        #1;
        // load-use pair, lw x0, lui consumer
        step(0, ADD,  LW5, 0, 0, 0);
        step(0, ADD,  NOP, 0, 0, 0);
        step(0, NOP,  NOP, 0, 0, 0);
        step(0, ADD,  LW0, 0, 0, 0);
        step(0, LUI5, LW5, 0, 0, 0);
        // load-use coinciding with a taken branch
        step(0, ADD,  LW5, 1, 0, 0);
        step(0, NOP,  NOP, 0, 0, 0);
        // three-cycle memory wait, zero-wait access, stray ack
        step(0, NOP,  NOP, 0, 1, 0);
        step(0, NOP,  NOP, 0, 1, 0);
        step(0, NOP,  NOP, 0, 1, 0);
        step(0, NOP,  NOP, 0, 1, 1);
        step(0, NOP,  NOP, 0, 1, 1);
        step(0, NOP,  NOP, 0, 0, 1);
        // memory wait pre-empting a multi-cycle load-use stall
        step(0, ADD,  LW5, 0, 0, 0);
        step(0, ADD,  NOP, 0, 1, 0);
        step(0, ADD,  NOP, 0, 1, 1);
        step(0, NOP,  NOP, 0, 0, 0);
        // reset in the middle of a memory wait
        step(0, NOP,  NOP, 0, 1, 0);
        step(0, NOP,  NOP, 0, 1, 0);
        step(1, NOP,  NOP, 0, 1, 0);
        step(0, NOP,  NOP, 0, 0, 0);
        step(0, NOP,  NOP, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), rand_instr(), rand_instr(),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
        end
        step(0, NOP, NOP, 0, 0, 0);
        @(posedge i_clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
